// File: rtl/segment_decoder.sv
// segment_decoder: debounces seven raw segment lines, decodes the accepted
// pattern to a 3-bit digit (0..7) and presents it through a valid/ready
// holding register.
// Optional feature: define SEG_ERRCNT_EN to add the 8-bit saturating
// err_count output that counts seg_error pulses.
module segment_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       seg_a,
    input  logic       seg_b,
    input  logic       seg_c,
    input  logic       seg_d,
    input  logic       seg_e,
    input  logic       seg_f,
    input  logic       seg_g,
    input  logic       out_ready,
    output logic [2:0] out_binary,
    output logic       out_valid,
    output logic       seg_error,
`ifdef SEG_ERRCNT_EN
    output logic [7:0] err_count,
`endif
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLING = 2'd1,
        STABLE   = 2'd2
    } state_t;

    // Counter value seen on the edge that completes the stable run.
    localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [6:0] seg_q, seg_in;
    logic [2:0] out_binary_q, out_binary_d;
    logic       out_valid_q, out_valid_d;
    logic       seg_error_q, seg_error_d;
    logic       overflow_q, overflow_d;
    logic       changed;
    logic       accept;
    logic       known;
    logic [2:0] digit;

    // a is the pattern MSB, g the LSB.
    assign seg_in  = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};
    // The sample captured this edge differs from the one already held.
    assign changed = (seg_in != seg_q);

    // Pattern decode of the held sample; blank and unknown codes report !known.
    always_comb begin
        known = 1'b1;
        digit = 3'd0;
        case (seg_q)
            7'b1111110: digit = 3'd0;
            7'b0110000: digit = 3'd1;
            7'b1101101: digit = 3'd2;
            7'b1111001: digit = 3'd3;
            7'b0110011: digit = 3'd4;
            7'b1011011: digit = 3'd5;
            7'b1011111: digit = 3'd6;
            7'b1110000: digit = 3'd7;
            default:    known = 1'b0;
        endcase
    end

    // Next state: any change restarts settling; a full run of equal samples accepts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (changed) begin
            state_d = SETTLING;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                SETTLING: begin
                    if (cnt_q == STABLE_LAST) begin
                        accept  = 1'b1;
                        state_d = STABLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: ;  // IDLE and STABLE hold on equal samples
            endcase
        end
    end

    // Output register: consume on handshake, load or drop on accept.
    always_comb begin
        out_binary_d = out_binary_q;
        out_valid_d  = out_valid_q;
        overflow_d   = overflow_q;
        seg_error_d  = 1'b0;
        if (out_valid_q && out_ready)
            out_valid_d = 1'b0;
        if (accept && (seg_q != 7'd0)) begin
            if (!known) begin
                seg_error_d = 1'b1;
            end else if (!out_valid_q || out_ready) begin
                out_binary_d = digit;
                out_valid_d  = 1'b1;
            end else begin
                // Holding register still full: keep the old digit, flag the loss.
                overflow_d = 1'b1;
            end
        end
    end

    // State, sample and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            seg_q        <= 7'd0;
            out_binary_q <= 3'd0;
            out_valid_q  <= 1'b0;
            seg_error_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            seg_q        <= seg_in;
            out_binary_q <= out_binary_d;
            out_valid_q  <= out_valid_d;
            seg_error_q  <= seg_error_d;
            overflow_q   <= overflow_d;
        end
    end

    assign out_binary = out_binary_q;
    assign out_valid  = out_valid_q;
    assign seg_error  = seg_error_q;
    assign overflow   = overflow_q;

`ifdef SEG_ERRCNT_EN
    logic [7:0] err_count_q, err_count_d;

    // Saturating count of error pulses, updated alongside the pulse itself.
    always_comb begin
        err_count_d = err_count_q;
        if (seg_error_d && (err_count_q != 8'd255))
            err_count_d = err_count_q + 8'd1;
    end

    // Error counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_count_q <= 8'd0;
        else     err_count_q <= err_count_d;
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_segment_decoder.sv
// Scoreboard bench for segment_decoder: stimulus pushes expected digits and
// error events; a negedge monitor pops them whenever the DUT presents one.
module tb_segment_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg = 7'd0;
    logic       out_ready = 1'b1;
    logic [2:0] out_binary;
    logic       out_valid;
    logic       seg_error;
    logic       overflow;
`ifdef SEG_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [2:0] dig_q[$];
    int err_pending = 0;

    always #5 clk = ~clk;

    segment_decoder #(.STABLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .seg_a(seg[6]), .seg_b(seg[5]), .seg_c(seg[4]), .seg_d(seg[3]),
        .seg_e(seg[2]), .seg_f(seg[1]), .seg_g(seg[0]),
        .out_ready(out_ready), .out_binary(out_binary), .out_valid(out_valid),
        .seg_error(seg_error),
`ifdef SEG_ERRCNT_EN
        .err_count(err_count),
`endif
        .overflow(overflow)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: each presented digit or error pulse must match the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (dig_q.size() == 0) begin
                    check("unexpected_digit", int'(out_binary), -1);
                end else begin
                    logic [2:0] e;
                    e = dig_q.pop_front();
                    check("digit", int'(out_binary), int'(e));
                end
            end
            if (seg_error) begin
                check("error_expected", int'(err_pending > 0), 1);
                if (err_pending > 0) err_pending--;
            end
        end
    end

    // Hold a recognised pattern from a different one, out_ready high.
    task automatic accept_digit(input logic [6:0] p, input logic [2:0] d, input string nm);
        seg = p;
        dig_q.push_back(d);
        tick();  // capture edge k
        repeat (3) begin
            tick();
            check({nm, "_early"}, int'(out_valid), 0);
        end
        tick();  // edge k+4
        check({nm, "_valid"}, int'(out_valid), 1);
        check({nm, "_bin"}, int'(out_binary), int'(d));
        tick();  // edge k+5, consumed
        check({nm, "_clear"}, int'(out_valid), 0);
    endtask

    initial begin
        logic [6:0] pats [8];
        int vcount;
        pats = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000};

        // Reset state
        #12;
        check("rst_valid", int'(out_valid), 0);
        check("rst_bin", int'(out_binary), 0);
        check("rst_err", int'(seg_error), 0);
        check("rst_ovf", int'(overflow), 0);
        rst = 1'b0;
        tick();

        // Basic latency with digit 3
        accept_digit(7'b1111001, 3'd3, "d3");

        // Full decode table
        for (int i = 0; i < 8; i++)
            accept_digit(pats[i], 3'(i), $sformatf("tbl%0d", i));

        // Glitch restarts settling
        seg = 7'b0110011;
        dig_q.push_back(3'd4);
        tick(); tick(); tick();
        seg = 7'b0110111;
        tick();
        seg = 7'b0110011;
        tick();
        repeat (3) begin
            tick();
            check("glitch_early", int'(out_valid), 0);
        end
        tick();
        check("glitch_valid", int'(out_valid), 1);
        check("glitch_bin", int'(out_binary), 4);
        tick();

        // Unrecognised pattern
        seg = 7'b1001111;
        err_pending++;
        tick();
        repeat (3) begin
            tick();
            check("err_early", int'(seg_error), 0);
        end
        tick();
        check("err_pulse", int'(seg_error), 1);
        check("err_novalid", int'(out_valid), 0);
`ifdef SEG_ERRCNT_EN
        check("err_count", int'(err_count), 1);
`endif
        tick();
        check("err_one_cycle", int'(seg_error), 0);

        // Overflow with out_ready low
        out_ready = 1'b0;
        seg = 7'b1101101;
        dig_q.push_back(3'd2);
        repeat (5) tick();
        check("ovf_valid", int'(out_valid), 1);
        check("ovf_bin2", int'(out_binary), 2);
        check("ovf_clear_yet", int'(overflow), 0);
        seg = 7'b1011011;
        repeat (5) tick();
        check("ovf_keep_bin", int'(out_binary), 2);
        check("ovf_set", int'(overflow), 1);
        out_ready = 1'b1;
        tick();
        check("ovf_drained", int'(out_valid), 0);
        check("ovf_sticky", int'(overflow), 1);

        // Reset mid-settle
        seg = 7'b1011111;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        check("mrst_valid", int'(out_valid), 0);
        check("mrst_bin", int'(out_binary), 0);
        check("mrst_err", int'(seg_error), 0);
        check("mrst_ovf", int'(overflow), 0);
`ifdef SEG_ERRCNT_EN
        check("mrst_errcnt", int'(err_count), 0);
`endif
        #1;
        rst = 1'b0;
        dig_q.push_back(3'd6);
        tick();
        repeat (3) begin
            tick();
            check("mrst_early", int'(out_valid), 0);
        end
        tick();
        check("mrst_valid6", int'(out_valid), 1);
        check("mrst_bin6", int'(out_binary), 6);
        tick();

        // Long hold produces one event; blank then same pattern produces another
        seg = 7'b1111110;
        dig_q.push_back(3'd0);
        vcount = 0;
        repeat (20) begin
            tick();
            if (out_valid) vcount++;
        end
        check("hold_events", vcount, 1);
        seg = 7'd0;
        vcount = 0;
        repeat (6) begin
            tick();
            if (out_valid || seg_error) vcount++;
        end
        check("blank_silent", vcount, 0);
        accept_digit(7'b1111110, 3'd0, "reacc");

        repeat (3) tick();
        check("sb_digits_left", dig_q.size(), 0);
        check("sb_errors_left", err_pending, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/segment_decoder.md
SEGMENT_DECODER -- requirements
Module: segment_decoder

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, number of consecutive equal samples required to accept a pattern (legal range 1..255).
REQ-002 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Ports: seg_a..seg_g  input  1 each  raw segment lines, active-high; a is pattern MSB, g is pattern LSB.
REQ-006 Port: out_binary  output  3  decoded digit 0..7.
REQ-007 Port: out_valid  output  1  out_binary holds an unconsumed digit.
REQ-008 Port: out_ready  input  1  consumer accepts the digit when out_valid and out_ready are both high at an edge.
REQ-009 Port: seg_error  output  1  one-cycle pulse when an unrecognised pattern is accepted.
REQ-010 Port: overflow  output  1  sticky flag; a digit was dropped because the holding register was full.

Function
REQ-011 The block SHALL register the 7 lines into seg_q on every edge and compare seg_q with its previous value.
REQ-012 The FSM SHALL have three states: IDLE (after reset), SETTLING (pattern changed, counting), and STABLE (pattern accepted, waiting for change).
REQ-013 Any edge where seg_q differs from its previous value SHALL clear the stability counter and enter SETTLING, from any state.
REQ-014 In SETTLING, each edge with an equal sample SHALL increment the counter; on the STABLE_CYCLES-th consecutive equal sample the pattern SHALL be accepted and the FSM SHALL enter STABLE.
REQ-015 Latency: a pattern first captured into seg_q at edge k SHALL be accepted at edge k+STABLE_CYCLES, with out_valid high after that edge.
REQ-016 Decode table (a..g): 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7.
REQ-017 Accepting blank (0000000) SHALL produce no digit and no error.
REQ-018 Accepting any other pattern SHALL pulse seg_error for one cycle and produce no digit.
REQ-019 Accepting a recognised pattern SHALL load out_binary and set out_valid.
REQ-020 A pattern equal to the last accepted pattern SHALL be re-accepted only after an intervening change (change, then change back).
REQ-021 out_valid SHALL clear on the edge where out_valid and out_ready are both high, unless a new digit is accepted on the same edge; in that case out_valid stays high and out_binary takes the new digit.
REQ-022 A digit accepted while out_valid is high and out_ready is low SHALL be dropped, out_binary SHALL be unchanged, and overflow SHALL set and hold until reset.
REQ-023 In STABLE, equal samples SHALL hold the counter and produce no further events.

Reset
REQ-024 Asserting rst at any time, including mid-settle, SHALL immediately force: state IDLE, counter 0, seg_q 0000000, out_binary 0, out_valid 0, seg_error 0, overflow 0, error count 0.
REQ-025 After rst deasserts, a pattern present on the inputs SHALL be treated as a change from blank and require the full STABLE_CYCLES to be accepted.

Configuration
REQ-026 With macro SEG_ERRCNT_EN defined, the block SHALL add output err_count (8 bits), which increments on each seg_error pulse and saturates at 255.
REQ-027 Without SEG_ERRCNT_EN, the err_count port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-028 STABLE_CYCLES=4, out_ready=1, hold 1111001 from edge k: out_valid=1 and out_binary=3 after edge k+4, then cleared after edge k+5.
REQ-029 Pattern 0110011 held 3 edges, then glitches to 0110111 for 1 edge, then returns: no output until 4 further equal samples; then out_binary=4.
REQ-030 Hold 1001111 for 4 samples: seg_error high exactly one cycle, out_valid stays 0; with SEG_ERRCNT_EN, err_count=1.
REQ-031 out_ready=0, accept digit 2, then change to digit 5 and accept it: out_binary stays 2, overflow=1; after out_ready=1 for one edge, out_valid=0 and overflow stays 1.
REQ-032 Assert rst two samples into settling on 1011111: all outputs 0 immediately; after release, digit 6 appears STABLE_CYCLES edges after capture.
REQ-033 Hold 1111110 for 20 cycles: exactly one out_valid event with out_binary=0; blank for 4 samples, then 1111110 again: a second event.
